// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch controller. Owns the program counter, issues one
// instruction-memory request at a time (req/ready) and holds each fetched
// word for decode (valid/accept). A PC-relative branch redirect from execute
// retargets the PC and discards any held word or in-flight response.
//
// Ports:
//   clk           in   system clock, all state updates on posedge
//   reset         in   synchronous active-high reset
//   stall         in   inhibits starting a new fetch (idle / holding only)
//   branch_req    in   redirect request from execute
//   branch_offset in   redirect offset; only the low ADDR_W bits are used
//   imem_req      out  fetch request (registered)
//   imem_addr     out  fetch address (registered, stable while imem_req=1)
//   imem_ready    in   memory returns imem_rdata this cycle
//   imem_rdata    in   fetched word
//   instr         out  held instruction
//   instr_pc      out  address the held instruction was fetched from
//   instr_valid   out  instr / instr_pc are valid
//   instr_accept  in   decode consumes instr
//   pc            out  next address to fetch
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        OFF_W    = 20,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_req,
    input  logic [OFF_W-1:0]  branch_offset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_accept,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_VALID = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic                imem_req_q, imem_req_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                instr_valid_q, instr_valid_d;

    logic [ADDR_W-1:0]   target_s;
    logic [ADDR_W-1:0]   pc_inc_s;

    // Upper offset bits do not take part in the modulo-2^ADDR_W target.
    logic                unused_offset_hi_s;
    assign unused_offset_hi_s = ^branch_offset[OFF_W-1:ADDR_W];

    // Branch target is relative to the address of the held/last instruction.
    assign target_s = instr_pc_q + branch_offset[ADDR_W-1:0];
    // Sequential PC; natural wrap at 2^ADDR_W.
    assign pc_inc_s = pc_q + ADDR_W'(4);

    // Next-state and datapath decisions; branch outranks handshakes and stall.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_addr_d = imem_addr_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;

        if (branch_req) begin
            pc_d = target_s;
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_VALID: state_d = ST_IDLE;
                // A request already on the bus must complete; its data is dropped.
                ST_WAIT: begin
                    if (imem_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!stall) begin
                        state_d     = ST_WAIT;
                        imem_addr_d = pc_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (imem_ready) begin
                        state_d    = ST_VALID;
                        instr_d    = imem_rdata;
                        instr_pc_d = imem_addr_q;
                        pc_d       = pc_inc_s;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_VALID: begin
                    if (instr_accept) begin
                        if (!stall) begin
                            // Back-to-back issue of the next sequential fetch.
                            state_d     = ST_WAIT;
                            imem_addr_d = pc_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_VALID;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs are decoded from the next state so they come out registered.
    always_comb begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        case (state_d)
            ST_WAIT:  imem_req_d    = 1'b1;
            ST_DRAIN: imem_req_d    = 1'b1;
            ST_VALID: instr_valid_d = 1'b1;
            ST_IDLE:  imem_req_d    = 1'b0;
            default:  imem_req_d    = 1'b0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            imem_addr_q   <= '0;
            imem_req_q    <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_addr_q   <= imem_addr_d;
            imem_req_q    <= imem_req_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed scenarios followed by randomized traffic. A transaction-level
// model (request outstanding / response to drop / word held) predicts every
// output after each clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int ADDR_W = 16;
    localparam int OFF_W  = 20;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              branch_req;
    logic [OFF_W-1:0]  branch_offset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_accept;
    logic [ADDR_W-1:0] pc;

    int total = 0;
    int bad   = 0;

    // Reference model
    bit                m_req;    // a request is on the bus
    bit                m_drop;   // its response must be thrown away
    bit                m_held;   // a word is held for decode
    logic [ADDR_W-1:0] m_pc, m_addr, m_ipc;
    logic [DATA_W-1:0] m_instr;

    fetch_sequencer #(
        .ADDR_W(ADDR_W), .OFF_W(OFF_W), .DATA_W(DATA_W), .RESET_PC(16'h0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_req   (branch_req),
        .branch_offset(branch_offset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_accept (instr_accept),
        .pc           (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_drop = 0; m_held = 0;
        m_pc = 16'h0000; m_addr = 16'h0000; m_ipc = 16'h0000; m_instr = 32'h0;
    endtask

    // One clock of behaviour, from the rules, using the inputs present at the edge.
    task automatic model_step();
        logic [ADDR_W-1:0] tgt;
        logic [31:0]       wide;
        if (reset) begin
            model_reset();
        end else if (branch_req) begin
            wide = 32'(m_ipc) + 32'(branch_offset);
            tgt  = wide[ADDR_W-1:0];
            m_pc   = tgt;
            m_held = 0;
            if (m_req) begin
                if (imem_ready) begin
                    m_req = 0; m_drop = 0;
                end else begin
                    m_drop = 1;
                end
            end
        end else if (m_req) begin
            if (imem_ready) begin
                m_req = 0;
                if (m_drop) begin
                    m_drop = 0;
                end else begin
                    m_held  = 1;
                    m_instr = imem_rdata;
                    m_ipc   = m_addr;
                    m_pc    = (m_pc + 16'd4) % 17'h10000;
                end
            end
        end else if (m_held) begin
            if (instr_accept) begin
                m_held = 0;
                if (!stall) begin
                    m_req = 1; m_addr = m_pc;
                end
            end
        end else if (!stall) begin
            m_req = 1; m_addr = m_pc;
        end
    endtask

    task automatic check_model();
        chk("imem_req",    32'(imem_req),    32'(m_req));
        chk("imem_addr",   32'(imem_addr),   32'(m_addr));
        chk("pc",          32'(pc),          32'(m_pc));
        chk("instr_valid", 32'(instr_valid), 32'(m_held));
        chk("instr",       instr,            m_instr);
        chk("instr_pc",    32'(instr_pc),    32'(m_ipc));
    endtask

    task automatic drive(input bit rst, input bit st, input bit br, input logic [OFF_W-1:0] off,
                         input bit rdy, input bit acc);
        reset = rst; stall = st; branch_req = br; branch_offset = off;
        imem_ready = rdy; instr_accept = acc; imem_rdata = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        model_reset();
        drive(1, 0, 0, 20'h0, 0, 0);
        tick();
        // Reset values
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);

        // Streaming: ready=1, accept=1
        drive(0, 0, 0, 20'h0, 1, 1);
        tick(); chk("stream_a0", 32'(imem_addr), 32'h0000); chk("stream_req0", 32'(imem_req), 32'h1);
        tick(); chk("stream_v0", 32'(instr_valid), 32'h1); chk("stream_ipc0", 32'(instr_pc), 32'h0000);
        tick(); chk("stream_a1", 32'(imem_addr), 32'h0004);
        // Ready delayed 3 cycles on 0x0004
        drive(0, 0, 0, 20'h0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("delay_req", 32'(imem_req), 32'h1); chk("delay_addr", 32'(imem_addr), 32'h0004);
        end
        drive(0, 0, 0, 20'h0, 1, 0);
        tick(); chk("delay_valid", 32'(instr_valid), 32'h1); chk("delay_pc", 32'(pc), 32'h0008);

        // Branch in VALID with instr_pc=0x0010, offset 0xFFFF0, accept same cycle
        drive(1, 0, 0, 20'h0, 0, 0); tick();
        drive(0, 1, 1, 20'h30010, 0, 0); tick(); chk("br_idle_pc", 32'(pc), 32'h0010);
        drive(0, 0, 0, 20'h0, 0, 0); tick();
        drive(0, 0, 0, 20'h0, 1, 0); tick(); chk("brv_ipc", 32'(instr_pc), 32'h0010);
        drive(0, 0, 1, 20'hFFFF0, 0, 1); tick();
        chk("brv_valid", 32'(instr_valid), 32'h0); chk("brv_pc", 32'(pc), 32'h0000);
        drive(0, 0, 0, 20'h0, 0, 0); tick(); chk("brv_addr", 32'(imem_addr), 32'h0000);

        // Branch in WAIT with ready=0, instr_pc=0x0008, offset 0x00020
        drive(1, 0, 0, 20'h0, 0, 0); tick();
        drive(0, 1, 1, 20'h00008, 0, 0); tick();
        drive(0, 0, 0, 20'h0, 1, 0); tick(); tick(); chk("brw_ipc", 32'(instr_pc), 32'h0008);
        drive(0, 0, 0, 20'h0, 0, 1); tick(); chk("brw_wait_addr", 32'(imem_addr), 32'h000C);
        drive(0, 0, 1, 20'h00020, 0, 0); tick(); chk("brw_drain_req", 32'(imem_req), 32'h1);
        drive(0, 1, 0, 20'h0, 0, 0); tick(); chk("brw_drain_hold", 32'(imem_addr), 32'h000C);
        drive(0, 1, 0, 20'h0, 1, 1); tick(); chk("brw_drop_valid", 32'(instr_valid), 32'h0);
        drive(0, 0, 0, 20'h0, 0, 0); tick(); chk("brw_next_addr", 32'(imem_addr), 32'h0028);

        // PC wrap and stall in VALID
        drive(1, 0, 0, 20'h0, 0, 0); tick();
        drive(0, 1, 1, 20'h0FFFC, 0, 0); tick();
        drive(0, 0, 0, 20'h0, 1, 0); tick(); tick(); chk("wrap_pc", 32'(pc), 32'h0000);
        drive(0, 1, 0, 20'h0, 1, 1); tick(); chk("stall_idle_req", 32'(imem_req), 32'h0);
        drive(0, 1, 0, 20'h0, 1, 0); tick(); chk("stall_hold_req", 32'(imem_req), 32'h0);
        drive(0, 0, 0, 20'h0, 0, 0); tick(); chk("wrap_addr", 32'(imem_addr), 32'h0000);

        // Reset during WAIT, late ready ignored
        drive(0, 0, 0, 20'h0, 0, 0); tick();
        drive(1, 0, 0, 20'h0, 0, 0); tick(); chk("rstw_req", 32'(imem_req), 32'h0); chk("rstw_pc", 32'(pc), 32'h0);
        drive(0, 1, 0, 20'h0, 1, 1); tick(); tick(); chk("rstw_valid", 32'(instr_valid), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                  20'($urandom), ($urandom % 2) == 0, ($urandom % 2) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences fetches from instruction memory. It issues one request at a time over a req/ready handshake and presents each fetched word to decode over a valid/accept handshake. It also applies PC-relative branch redirects, discarding any in-flight or held fetch. It sits between the instruction memory port and the decode stage, with the execute stage driving redirects.

## Interface
- ADDR_W, 16, PC and instruction-memory address width
- OFF_W, 20, branch offset input width
- DATA_W, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- stall  in  1  inhibits starting a new fetch (IDLE/VALID only)
- branch_req  in  1  redirect request from execute
- branch_offset  in  OFF_W  redirect offset
- imem_req  out  1  fetch request, registered
- imem_addr  out  ADDR_W  fetch address, registered, stable while imem_req=1
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  DATA_W  fetched word
- instr  out  DATA_W  held instruction
- instr_pc  out  ADDR_W  address instr was fetched from
- instr_valid  out  1  instr/instr_pc valid
- instr_accept  in  1  decode consumes instr (meaningful only when instr_valid=1)
- pc  out  ADDR_W  next address to fetch

## Operation
- States: IDLE, WAIT (request outstanding), VALID (instruction held), DRAIN (outstanding request whose data is discarded).
- Outputs per state: imem_req=1 in WAIT and DRAIN; instr_valid=1 in VALID only.
- IDLE:
  - !stall → WAIT, imem_addr<=pc.
  - stall → stay IDLE.
- WAIT:
  - imem_ready=0 → stay WAIT; imem_addr held.
  - imem_ready=1 → VALID; instr<=imem_rdata, instr_pc<=imem_addr, pc<=pc+4.
- VALID:
  - instr_accept=0 → hold instr, instr_pc, instr_valid.
  - instr_accept=1 and !stall → WAIT, imem_addr<=pc (back-to-back issue).
  - instr_accept=1 and stall → IDLE.
- DRAIN:
  - Hold imem_req and imem_addr until imem_ready=1, then → IDLE.
  - Returned data is dropped; instr, instr_pc and pc are not modified by the response.
- Branch (branch_req=1): target = (instr_pc + branch_offset[ADDR_W-1:0]) mod 2^ADDR_W; branch_offset[OFF_W-1:ADDR_W] is ignored.
  - pc<=target in every state.
  - IDLE → IDLE.
  - VALID → IDLE; instr_valid cleared even if instr_accept=1 the same cycle.
  - WAIT with imem_ready=0 → DRAIN.
  - WAIT with imem_ready=1 → IDLE; data dropped, pc<=target (not pc+4).
  - DRAIN: stays DRAIN (or → IDLE on ready); pc<=latest target.
- Priority: reset > branch_req > imem_ready/instr_accept > stall.
- Arithmetic: all PC math is modulo 2^ADDR_W; 0xFFFC+4 = 0x0000.
- stall never aborts WAIT or DRAIN; an issued request is always held until imem_ready.

## Timing
- Reset values, one cycle after reset=1 at an edge:
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0.
  - instr=0, instr_pc=0, instr_valid=0.
- Reset mid-WAIT/DRAIN: imem_req drops the next cycle; any later imem_ready is ignored in IDLE.
- Latency: reset released with stall=0 → imem_req=1 next cycle → with imem_ready=1 immediately, instr_valid=1 on the cycle after.
- Throughput, with ready=1 and accept=1 at first opportunity: one instruction per 2 cycles.
- imem_ready is sampled only while imem_req=1.
- Branch takes effect at the edge where branch_req=1. The first request to target is issued on the following edge, provided state is IDLE and stall=0.

## Test plan
- Reset, stall=0, ready=1, accept=1: imem_addr 0x0000, 0x0004, 0x0008; instr_pc matches each; instr_valid every other cycle.
- Ready delayed 3 cycles on address 0x0004: imem_req and imem_addr=0x0004 held 4 cycles; instr_valid rises the cycle after ready; pc=0x0008.
- Branch in VALID with instr_pc=0x0010, branch_offset=0xFFFF0, accept=1 same cycle: instr_valid→0; next imem_addr=0x0000.
- Branch in WAIT with ready=0, offset=0x00020, instr_pc=0x0008: DRAIN; the returned word never raises instr_valid; next imem_addr=0x0028.
- PC wrap: fetch at 0xFFFC completes → pc=0x0000, next imem_addr=0x0000. Stall=1 in VALID with accept=1 → IDLE, no imem_req until stall=0.
- reset=1 during WAIT: imem_req=0 next cycle, pc=RESET_PC; late imem_ready=1 produces no instr_valid.
